// File: rtl/uart_alu_ctrl_if.sv
// Bundle of the Rx/Tx/ALU handshake and data signals seen by the UART-ALU sequencer.
// master is the sequencer side; slave is the Rx/ALU/Tx side.
interface uart_alu_ctrl_if #(
    parameter int DBIT = 8
);
    logic            rx_done_tick;
    logic [DBIT-1:0] rx_data;
    logic            tx_done_tick;
    logic [DBIT-1:0] alu_result;
    logic [DBIT-1:0] op_a;
    logic [DBIT-1:0] op_b;
    logic [DBIT-1:0] op_code;
    logic [DBIT-1:0] tx_data;
    logic            tx_start;
    logic            busy;
    logic            frame_err;
    logic            overrun;

    modport master (
        input  rx_done_tick, rx_data, tx_done_tick, alu_result,
        output op_a, op_b, op_code, tx_data, tx_start, busy, frame_err, overrun
    );

    modport slave (
        output rx_done_tick, rx_data, tx_done_tick, alu_result,
        input  op_a, op_b, op_code, tx_data, tx_start, busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Sequencer collecting an A/B/opcode frame from the UART receiver, running the ALU
// and launching one transmit of the result, with inter-byte timeout and overrun flags.
module uart_alu_ctrl #(
    parameter int DBIT           = 8,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  logic           clk,
    input  logic           reset,
    uart_alu_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        GET_B   = 3'd1,
        GET_OP  = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_t;

    state_t          state_r, state_s;
    logic [DBIT-1:0] op_a_r, op_a_s;
    logic [DBIT-1:0] op_b_r, op_b_s;
    logic [DBIT-1:0] op_code_r, op_code_s;
    logic [DBIT-1:0] tx_data_r, tx_data_s;
    logic            tx_start_r, tx_start_s;
    logic            frame_err_r, frame_err_s;
    logic            overrun_r, overrun_s;
    logic [TO_W-1:0] cnt_r, cnt_s;
    logic            rx_prev_r, tx_prev_r;
    logic            rx_ev_s, tx_ev_s, to_hit_s;

    // Done flags may be held for many cycles; only their rising edge is an event.
    assign rx_ev_s  = bus.rx_done_tick & ~rx_prev_r;
    assign tx_ev_s  = bus.tx_done_tick & ~tx_prev_r;
    assign to_hit_s = (cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

    // State, datapath and edge-detect registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= GET_A;
            op_a_r      <= '0;
            op_b_r      <= '0;
            op_code_r   <= '0;
            tx_data_r   <= '0;
            tx_start_r  <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            cnt_r       <= '0;
            rx_prev_r   <= 1'b1;
            tx_prev_r   <= 1'b1;
        end else begin
            state_r     <= state_s;
            op_a_r      <= op_a_s;
            op_b_r      <= op_b_s;
            op_code_r   <= op_code_s;
            tx_data_r   <= tx_data_s;
            tx_start_r  <= tx_start_s;
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
            cnt_r       <= cnt_s;
            rx_prev_r   <= bus.rx_done_tick;
            tx_prev_r   <= bus.tx_done_tick;
        end
    end

    // Next-state and next-output decode; pulses are computed one cycle ahead so they leave registered.
    always_comb begin
        state_s     = state_r;
        op_a_s      = op_a_r;
        op_b_s      = op_b_r;
        op_code_s   = op_code_r;
        tx_data_s   = tx_data_r;
        tx_start_s  = 1'b0;
        frame_err_s = 1'b0;
        overrun_s   = 1'b0;
        cnt_s       = cnt_r;
        case (state_r)
            GET_A: begin
                if (rx_ev_s) begin
                    op_a_s  = bus.rx_data;
                    cnt_s   = '0;
                    state_s = GET_B;
                end else begin
                    state_s = GET_A;
                end
            end
            GET_B: begin
                if (rx_ev_s) begin
                    op_b_s  = bus.rx_data;
                    cnt_s   = '0;
                    state_s = GET_OP;
                end else if (to_hit_s) begin
                    frame_err_s = 1'b1;
                    cnt_s       = '0;
                    state_s     = GET_A;
                end else begin
                    cnt_s = cnt_r + TO_W'(1);
                end
            end
            GET_OP: begin
                if (rx_ev_s) begin
                    op_code_s = bus.rx_data;
                    cnt_s     = '0;
                    state_s   = EXEC;
                end else if (to_hit_s) begin
                    frame_err_s = 1'b1;
                    cnt_s       = '0;
                    state_s     = GET_A;
                end else begin
                    cnt_s = cnt_r + TO_W'(1);
                end
            end
            EXEC: begin
                // ALU has had this cycle to settle on the new opcode.
                tx_data_s  = bus.alu_result;
                tx_start_s = 1'b1;
                overrun_s  = rx_ev_s;
                state_s    = SEND;
            end
            SEND: begin
                overrun_s = rx_ev_s;
                state_s   = WAIT_TX;
            end
            WAIT_TX: begin
                overrun_s = rx_ev_s;
                if (tx_ev_s) begin
                    state_s = GET_A;
                end else begin
                    state_s = WAIT_TX;
                end
            end
            default: begin
                state_s   = GET_A;
                op_a_s    = '0;
                op_b_s    = '0;
                op_code_s = '0;
                tx_data_s = '0;
                cnt_s     = '0;
            end
        endcase
    end

    assign bus.op_a      = op_a_r;
    assign bus.op_b      = op_b_r;
    assign bus.op_code   = op_code_r;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_start  = tx_start_r;
    assign bus.frame_err = frame_err_r;
    assign bus.overrun   = overrun_r;
    assign bus.busy      = (state_r != GET_A);
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed and randomized bench for uart_alu_ctrl with a behavioural ALU and frame model.
module tb_uart_alu_ctrl;
    localparam int DBIT = 8;
    localparam int TOC  = 100;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    uart_alu_ctrl_if #(.DBIT(DBIT)) bus ();

    uart_alu_ctrl #(.DBIT(DBIT), .TIMEOUT_CYCLES(TOC), .TO_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        case (op)
            8'h20:   return a + b;
            8'h22:   return a - b;
            8'h24:   return a & b;
            8'h25:   return a | b;
            8'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign bus.alu_result = ref_alu(bus.op_a, bus.op_b, bus.op_code);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Raise rx_done_tick for 'hold' cycles; the byte is captured at the first edge.
    task automatic send_byte(input logic [7:0] b, input int hold);
        bus.rx_data      = b;
        bus.rx_done_tick = 1'b1;
        repeat (hold) tick();
        bus.rx_done_tick = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk8({tag, "_op_a"}, bus.op_a, 8'h00);
        chk8({tag, "_op_b"}, bus.op_b, 8'h00);
        chk8({tag, "_op_code"}, bus.op_code, 8'h00);
        chk8({tag, "_tx_data"}, bus.tx_data, 8'h00);
        chk1({tag, "_tx_start"}, bus.tx_start, 1'b0);
        chk1({tag, "_frame_err"}, bus.frame_err, 1'b0);
        chk1({tag, "_overrun"}, bus.overrun, 1'b0);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        int n;
        logic seen;
        logic [7:0] a, b, op, exp_res;
        logic [7:0] ops [5];
        ops[0] = 8'h20; ops[1] = 8'h22; ops[2] = 8'h24; ops[3] = 8'h25; ops[4] = 8'h26;

        reset            = 1'b1;
        bus.rx_done_tick = 1'b0;
        bus.rx_data      = 8'h00;
        bus.tx_done_tick = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Basic frame 5 + 3
        send_byte(8'h05, 1);
        chk8("t1_op_a", bus.op_a, 8'h05);
        chk1("t1_busy_get_b", bus.busy, 1'b1);
        tick();
        send_byte(8'h03, 1);
        chk8("t1_op_b", bus.op_b, 8'h03);
        tick();
        send_byte(8'h20, 1);
        chk8("t1_op_code", bus.op_code, 8'h20);
        chk1("t1_no_start_in_exec", bus.tx_start, 1'b0);
        tick();
        chk1("t1_tx_start", bus.tx_start, 1'b1);
        chk8("t1_tx_data", bus.tx_data, 8'h08);
        tick();
        chk1("t1_tx_start_pulse", bus.tx_start, 1'b0);
        chk1("t1_busy_wait_tx", bus.busy, 1'b1);
        bus.tx_done_tick = 1'b1;
        tick();
        chk1("t1_busy_drop", bus.busy, 1'b0);
        repeat (3) tick();
        bus.tx_done_tick = 1'b0;
        tick();

        // Held rx flag: one capture only
        bus.rx_data      = 8'hAA;
        bus.rx_done_tick = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.overrun) seen = 1'b1;
        end
        bus.rx_done_tick = 1'b0;
        tick();
        chk8("t2_op_a", bus.op_a, 8'hAA);
        chk8("t2_op_b_kept", bus.op_b, 8'h03);
        chk1("t2_busy", bus.busy, 1'b1);
        chk1("t2_no_overrun", seen, 1'b0);
        n = 0;
        while (n < 2 * TOC && !bus.frame_err) begin
            tick();
            n++;
        end
        chk1("t2_timeout_seen", bus.frame_err, 1'b1);
        tick();

        // Timeout latency from the captured byte
        send_byte(8'h11, 1);
        n = 0;
        while (n < 2 * TOC && !bus.frame_err) begin
            tick();
            n++;
        end
        chkn("t3_timeout_latency", n, TOC);
        chk1("t3_busy_after_timeout", bus.busy, 1'b0);
        chk8("t3_op_a_kept", bus.op_a, 8'h11);
        tick();
        chk1("t3_frame_err_pulse", bus.frame_err, 1'b0);
        send_byte(8'h22, 1);
        chk8("t3_next_op_a", bus.op_a, 8'h22);
        chk1("t3_busy", bus.busy, 1'b1);

        // Byte arrives exactly on the last timeout cycle
        repeat (TOC - 1) tick();
        send_byte(8'h33, 1);
        chk1("t6_race_no_frame_err", bus.frame_err, 1'b0);
        chk8("t6_race_op_b", bus.op_b, 8'h33);
        chk1("t6_race_busy", bus.busy, 1'b1);
        tick();
        chk1("t6_race_no_frame_err2", bus.frame_err, 1'b0);

        // Overrun while waiting for Tx
        send_byte(8'h20, 1);
        tick();
        chk1("t4_tx_start", bus.tx_start, 1'b1);
        chk8("t4_tx_data", bus.tx_data, 8'h55);
        tick();
        send_byte(8'h77, 1);
        chk1("t4_overrun", bus.overrun, 1'b1);
        chk8("t4_tx_data_kept", bus.tx_data, 8'h55);
        chk1("t4_busy", bus.busy, 1'b1);
        tick();
        chk1("t4_overrun_pulse", bus.overrun, 1'b0);
        bus.tx_done_tick = 1'b1;
        tick();
        chk1("t4_busy_drop", bus.busy, 1'b0);
        bus.tx_done_tick = 1'b0;
        tick();
        send_byte(8'h09, 1);
        chk8("t4_clean_op_a", bus.op_a, 8'h09);
        tick();
        send_byte(8'h04, 1);
        tick();
        send_byte(8'h22, 1);
        tick();
        chk1("t4_clean_tx_start", bus.tx_start, 1'b1);
        chk8("t4_clean_tx_data", bus.tx_data, 8'h05);
        tick();
        bus.tx_done_tick = 1'b1;
        tick();
        bus.tx_done_tick = 1'b0;
        tick();

        // Reset in GET_OP, released with rx flag still high
        send_byte(8'h01, 1);
        tick();
        send_byte(8'h02, 1);
        tick();
        reset            = 1'b1;
        bus.rx_data      = 8'h5A;
        bus.rx_done_tick = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk_reset_outputs("t5_after_reset");
        repeat (3) tick();
        chk8("t5_no_capture", bus.op_a, 8'h00);
        chk1("t5_idle", bus.busy, 1'b0);
        bus.rx_done_tick = 1'b0;
        tick();

        // Randomized frames against the reference model
        for (int f = 0; f < 20; f++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = ops[$urandom_range(4, 0)];
            exp_res = ref_alu(a, b, op);
            send_byte(a, $urandom_range(4, 1));
            repeat ($urandom_range(3, 1)) tick();
            send_byte(b, $urandom_range(4, 1));
            repeat ($urandom_range(3, 1)) tick();
            send_byte(op, 1);
            n = 0;
            while (n < 8 && !bus.tx_start) begin
                tick();
                n++;
            end
            chkn("rnd_start_latency", n, 1);
            chk8("rnd_tx_data", bus.tx_data, exp_res);
            tick();
            chk1("rnd_start_pulse", bus.tx_start, 1'b0);
            if ($urandom_range(1, 0) == 1) begin
                send_byte(8'($urandom), 1);
                chk1("rnd_overrun", bus.overrun, 1'b1);
                tick();
            end
            repeat ($urandom_range(3, 0)) tick();
            chk1("rnd_busy_before_done", bus.busy, 1'b1);
            bus.tx_done_tick = 1'b1;
            tick();
            chk1("rnd_busy_drop", bus.busy, 1'b0);
            repeat ($urandom_range(3, 0)) tick();
            bus.tx_done_tick = 1'b0;
            tick();
            chk8("rnd_tx_data_hold", bus.tx_data, exp_res);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
- Sequencer between the UART receiver, a combinational ALU and the UART transmitter.
- Collects a 3-byte command frame from the receiver in this order: operand A, operand B, opcode.
- Presents the frame to the ALU, latches the result and launches one transmit of the result byte.
- Sits in the top-level UART-ALU path; the baud tick generator, Rx and Tx instances stay unchanged.

Parameters:
- DBIT, 8, data byte width; matches Rx/Tx data width.
- TIMEOUT_CYCLES, 1000000, max clk cycles allowed between consecutive frame bytes before the partial frame is discarded.
- TO_W, 20, width of the inter-byte timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_done_tick  in  1  Rx byte-complete flag; may stay high for many clk cycles.
- rx_data  in  DBIT  Rx received byte; valid when rx_done_tick rises.
- tx_done_tick  in  1  Tx byte-sent flag; may stay high for many clk cycles.
- alu_result  in  DBIT  combinational ALU output for op_a/op_b/op_code.
- op_a  out  DBIT  registered operand A to ALU.
- op_b  out  DBIT  registered operand B to ALU.
- op_code  out  DBIT  registered opcode to ALU.
- tx_data  out  DBIT  byte to transmit; stable from the tx_start pulse until tx_done_tick rises.
- tx_start  out  1  one-clk pulse launching Tx.
- busy  out  1  high in any state other than GET_A.
- frame_err  out  1  one-clk pulse when a partial frame is discarded on timeout.
- overrun  out  1  one-clk pulse when a byte arrives while executing or transmitting.

Behaviour:
- Reset: state=GET_A.
- Reset: op_a=op_b=op_code=tx_data=0; tx_start=frame_err=overrun=0; busy=0; timeout counter=0.
- Reset: rx_prev and tx_prev (edge-detect registers) are set to 1, so a level held high across reset release is not treated as an event.
- Events: rx_ev = rx_done_tick & ~rx_prev; tx_ev = tx_done_tick & ~tx_prev. Both prev registers update every cycle. Exactly one event per rising edge, regardless of how long the flag stays high.
- GET_A: on rx_ev, op_a<=rx_data, counter<=0, go to GET_B.
- GET_B: on rx_ev, op_b<=rx_data, counter<=0, go to GET_OP.
- GET_OP: on rx_ev, op_code<=rx_data, go to EXEC.
- Timeout (GET_B/GET_OP only): counter increments each cycle without rx_ev. When counter==TIMEOUT_CYCLES-1 and there is no rx_ev, pulse frame_err for 1 cycle, go to GET_A, and leave op registers as they are.
- rx_ev wins over timeout in the same cycle.
- EXEC: exactly 1 cycle, allowing the ALU to settle from the new op_code; tx_data<=alu_result; go to SEND.
- SEND: tx_start=1 for this single cycle; go to WAIT_TX.
- WAIT_TX: on tx_ev, go to GET_A. There is no timeout in this state.
- Overrun: rx_ev in EXEC, SEND or WAIT_TX pulses overrun for 1 cycle. The byte is dropped, state is unaffected, and it is not stored as the next op_a.
- Latency: EXEC is entered 1 clk after the opcode rx_ev; tx_start is asserted 2 clks after that rx_ev; busy drops 1 clk after tx_ev.
- Unused state encodings go to GET_A with outputs at reset values.
- Reset mid-frame or mid-transmit: the partial frame is abandoned and tx_start is not reissued.
- All outputs are registered except busy, which is decoded from state.

Test Plan:
- Basic frame: rx bytes 0x05, 0x03, 0x20 with the bench ALU model returning 0x08 → op_a=0x05, op_b=0x03, op_code=0x20; tx_data=0x08; single tx_start pulse 2 clks after the third rx_ev; busy low 1 clk after tx_done_tick rises.
- Held flag: rx_done_tick held high for 16 clks with rx_data=0xAA → exactly one capture (op_a=0xAA), state GET_B; no overrun.
- Timeout: TIMEOUT_CYCLES=100; send 0x11 then nothing → frame_err pulses 100 clks after the rx_ev; then state GET_A with busy=0; the next byte 0x22 lands in op_a.
- Overrun: byte 0x77 arrives during WAIT_TX → overrun 1-cycle pulse; tx_data unchanged; after tx_done_tick the next frame starts cleanly with op_a ≠ 0x77.
- Reset mid-operation: reset asserted in GET_OP, then released with rx_done_tick held high → all outputs at reset values; no spurious rx_ev; state GET_A.
- Boundary race: rx_ev in the same cycle the counter hits TIMEOUT_CYCLES-1 in GET_B → byte accepted, no frame_err.
